uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL run on one clock with a synchronous, active-low reset.
REQ-002 Parameter CLKS_PER_BIT, default 16, SHALL set clock cycles per serial bit (legal range 2..65535).
REQ-003 Parameter PARITY_EN, default 0, SHALL insert an even-parity bit between the data and stop bits when 1.
REQ-004 Port clk  input  1  rising-edge clock; it SHALL be the same clock as the upstream fifo read side (clk_out).
REQ-005 Port reset_n  input  1  synchronous active-low reset.
REQ-006 Port fifo_data  input  8  fifo read data, valid the cycle after fifo_rd_en.
REQ-007 Port fifo_empty  input  1  fifo empty flag.
REQ-008 Port fifo_rd_en  output  1  one-cycle pop strobe to the fifo enable_out.
REQ-009 Port tx_enable  input  1  permits new frames; when low, a frame in progress completes.
REQ-010 Port tx  output  1  serial line, idle high.
REQ-011 Port busy  output  1  high from pop issue to the end of the stop bit.
REQ-012 Port frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE -> POP when tx_enable=1 and fifo_empty=0; fifo_rd_en=1 in POP only.
- POP -> LOAD unconditionally; LOAD captures fifo_data into an 8-bit shift register.
- LOAD -> START; START, DATA, PARITY and STOP each hold for CLKS_PER_BIT cycles per bit.
- DATA shifts LSB first for 8 bits; DATA -> PARITY if PARITY_EN=1, else -> STOP.
- STOP -> POP in its last cycle if tx_enable=1 and fifo_empty=0; otherwise -> IDLE.
REQ-014 tx SHALL be registered: 0 during START, data bit during DATA, XOR of the 8 data bits during PARITY, 1 in all other states.
REQ-015 Latency from the first IDLE cycle sampling fifo_empty=0 to tx falling SHALL be 3 clocks.
REQ-016 Back-to-back frames SHALL have exactly 2 idle-high cycles (POP, LOAD) between the stop bit and the next start bit.
REQ-017 fifo_rd_en SHALL never be asserted while fifo_empty=1 was sampled in the deciding cycle, and SHALL never be high for 2 consecutive cycles.
REQ-018 The bit-period counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, and reset to 0 on every bit boundary; the bit index SHALL be 3 bits and wrap only on state exit.
REQ-019 tx_enable falling mid-frame SHALL not truncate the frame; no further pop SHALL follow.
REQ-020 fifo_empty changing during START..STOP SHALL have no effect until the STOP decision cycle.
REQ-021 busy SHALL equal 1 in every state except IDLE.

Reset
REQ-022 With reset_n=0 at a clock edge, the block SHALL enter IDLE with tx=1, fifo_rd_en=0, busy=0, frame_done=0, and counters at 0, including mid-frame; no partial frame SHALL resume.
REQ-023 The first pop after reset SHALL be possible on the first edge with reset_n=1.

Structure
REQ-024 The state encodings (3-bit) and the UART bit-count constant 8 SHALL live in a shared package, uart_pkg.
REQ-025 The bit-period counter SHALL be one sub-module, baud_tick, which outputs a last-cycle tick.
REQ-026 RTL SHALL be single-process FSM plus datapath, no latches, no combinational output paths from inputs.

Verification
REQ-027 Using CLKS_PER_BIT=4 and PARITY_EN=0, push 0x35 -> tx=0,1,0,1,0,1,1,0,0,1, each bit held 4 cycles, and a single frame_done pulse.
REQ-028 Using PARITY_EN=1, push 0x35 then 0x07 -> parity bits 0 then 1, and 11-bit frames.
REQ-029 Push 0x35..0x3C (8 bytes) with the fifo from the fifo block (DATA_WIDTH=8, FIFO_POWER=4) -> 8 frames in order, exactly 2 high cycles between frames, and 8 fifo_rd_en pulses.
REQ-030 Empty fifo with tx_enable=1 for 100 cycles -> fifo_rd_en=0, tx=1, busy=0 throughout.
REQ-031 Drive reset_n=0 during DATA bit 3 -> next cycle tx=1 and busy=0; after release, the fifo byte remaining at its head is sent complete.
REQ-032 Drop tx_enable during START with 2 bytes queued -> the first frame completes, and there is no second pop until tx_enable=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame sizing and counter widths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W      = 3;
  localparam int unsigned BAUD_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and restarts at every bit boundary.
module baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick_c,
  output logic pre_tick_c
);

  localparam logic [BAUD_CNT_W-1:0] CNT_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_CNT_W-1:0] CNT_PRE  = BAUD_CNT_W'(CLKS_PER_BIT - 2);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;

  always_comb begin
    tick_c     = run && (cnt_q == CNT_LAST);
    pre_tick_c = run && (cnt_q == CNT_PRE);
    cnt_d      = cnt_q + BAUD_CNT_W'(1);
    if (!run || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter that pops bytes from a synchronous FIFO and serialises them
// as start, 8 data bits LSB first, optional even parity, stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [UART_DATA_BITS-1:0] fifo_data,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic                      tx_enable,
  output logic                      tx,
  output logic                      busy,
  output logic                      frame_done
);

  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                      parity_q, parity_d;
  logic                      tx_q, tx_d;
  logic                      rd_en_q, rd_en_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;

  logic run_c;
  logic tick_c;
  logic pre_tick_c;
  logic pop_ok_c;

  assign run_c    = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
  assign pop_ok_c = tx_enable && !fifo_empty;

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run_c),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: begin
        if (pop_ok_c) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        state_d  = START;
        shift_d  = fifo_data;
        parity_d = even_parity(fifo_data);
      end
      START: begin
        if (tick_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_c) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == BIT_LAST) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick_c) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick_c) begin
          state_d = pop_ok_c ? POP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with state_q.
  always_comb begin
    tx_d         = 1'b1;
    rd_en_d      = (state_d == POP);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_q == STOP) && pre_tick_c;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (no parity / even parity) fed from one FIFO model,
// every cycle compared against a waveform built from the frame rules.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 4;
  localparam logic [3:0]  IDLE_V = 4'b0010;   // {rd_en, busy, tx, frame_done}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       tx_enable;

  logic [7:0] mem [16];
  int         wr_cnt   = 0;
  int         rd_cnt_a = 0;
  int         rd_cnt_b = 0;
  logic [7:0] fd_a = '0;
  logic [7:0] fd_b = '0;
  logic       fe_a, fe_b;
  logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  assign fe_a = (wr_cnt == rd_cnt_a);
  assign fe_b = (wr_cnt == rd_cnt_b);

  // Synchronous FIFO read sides: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (rd_a) begin
      fd_a     <= mem[rd_cnt_a[3:0]];
      rd_cnt_a <= rd_cnt_a + 1;
    end
  end

  always @(posedge clk) begin
    if (rd_b) begin
      fd_b     <= mem[rd_cnt_b[3:0]];
      rd_cnt_b <= rd_cnt_b + 1;
    end
  end

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_data  (fd_a),
    .fifo_empty (fe_a),
    .fifo_rd_en (rd_a),
    .tx_enable  (tx_enable),
    .tx         (tx_a),
    .busy       (busy_a),
    .frame_done (done_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_data  (fd_b),
    .fifo_empty (fe_b),
    .fifo_rd_en (rd_b),
    .tx_enable  (tx_enable),
    .tx         (tx_b),
    .busy       (busy_b),
    .frame_done (done_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] frame_q [$];
  logic [3:0] exp_a [$];
  logic [3:0] exp_b [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_cnt[3:0]] = b;
    wr_cnt++;
  endtask

  task automatic push_exp(input bit par, input logic [3:0] v);
    if (par) exp_b.push_back(v);
    else     exp_a.push_back(v);
  endtask

  // One frame: POP, LOAD, then start/data/[parity]/stop bits, each CPB cycles.
  task automatic add_frame(input logic [7:0] d, input bit par);
    logic bits [$];
    logic last;
    bits.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par) bits.push_back(^d);
    bits.push_back(1'b1);
    push_exp(par, 4'b1110);
    push_exp(par, 4'b0110);
    for (int j = 0; j < bits.size(); j++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        last = (j == bits.size() - 1) && (c == int'(CPB) - 1);
        push_exp(par, {1'b0, 1'b1, bits[j], last});
      end
    end
  endtask

  task automatic build_exp();
    exp_a.delete();
    exp_b.delete();
    foreach (frame_q[k]) begin
      add_frame(frame_q[k], 1'b0);
      add_frame(frame_q[k], 1'b1);
    end
  endtask

  function automatic int run_len();
    return ((exp_a.size() > exp_b.size()) ? exp_a.size() : exp_b.size()) + 8;
  endfunction

  // act 1: push act_byte, act 2: drop tx_enable, both just before cycle act_idx.
  task automatic run_check(input int n, input int act_idx, input int act,
                           input logic [7:0] act_byte, input string tag);
    logic [3:0] ea, eb;
    for (int i = 0; i < n; i++) begin
      if (i == act_idx) begin
        if (act == 1) push_byte(act_byte);
        else if (act == 2) tx_enable = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      ea = (i < exp_a.size()) ? exp_a[i] : IDLE_V;
      eb = (i < exp_b.size()) ? exp_b[i] : IDLE_V;
      check($sformatf("%s a[%0d]", tag, i), {28'd0, rd_a, busy_a, tx_a, done_a}, {28'd0, ea});
      check($sformatf("%s b[%0d]", tag, i), {28'd0, rd_b, busy_b, tx_b, done_b}, {28'd0, eb});
    end
  endtask

  task automatic send_queued(input string tag);
    foreach (frame_q[k]) push_byte(frame_q[k]);
    build_exp();
    tx_enable = 1'b1;
    run_check(run_len(), -1, 0, 8'h00, tag);
    tx_enable = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset a", {28'd0, rd_a, busy_a, tx_a, done_a}, {28'd0, IDLE_V});
    check("reset b", {28'd0, rd_b, busy_b, tx_b, done_b}, {28'd0, IDLE_V});
    reset_n = 1'b1;

    // Empty FIFO with transmit permitted: nothing may happen.
    frame_q.delete();
    build_exp();
    tx_enable = 1'b1;
    run_check(100, -1, 0, 8'h00, "empty");
    tx_enable = 1'b0;

    frame_q = '{8'h35};
    send_queued("single35");

    frame_q = '{8'h35, 8'h07};
    send_queued("par3507");

    frame_q.delete();
    for (int k = 0; k < 8; k++) frame_q.push_back(8'(8'h35 + k));
    send_queued("burst8");

    for (int r = 0; r < 4; r++) begin
      frame_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) frame_q.push_back(8'($urandom));
      send_queued($sformatf("rand%0d", r));
    end

    // Byte arriving mid-frame is only noticed at the stop decision.
    frame_q = '{8'hA5, 8'h5A};
    push_byte(8'hA5);
    build_exp();
    tx_enable = 1'b1;
    run_check(run_len(), 5, 1, 8'h5A, "midpush");
    tx_enable = 1'b0;

    // tx_enable dropped during START: frame completes, no further pop.
    frame_q = '{8'hC3};
    push_byte(8'hC3);
    push_byte(8'h3C);
    build_exp();
    tx_enable = 1'b1;
    run_check(run_len(), 3, 2, 8'h00, "dropen");
    frame_q.delete();
    build_exp();
    run_check(20, -1, 0, 8'h00, "held");
    frame_q = '{8'h3C};
    build_exp();
    tx_enable = 1'b1;
    run_check(run_len(), -1, 0, 8'h00, "resume");
    tx_enable = 1'b0;

    // Reset during data bit 3, then the next queued byte goes out whole.
    frame_q = '{8'h96, 8'h69};
    push_byte(8'h96);
    push_byte(8'h69);
    build_exp();
    tx_enable = 1'b1;
    run_check(19, -1, 0, 8'h00, "prerst");
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst a", {28'd0, rd_a, busy_a, tx_a, done_a}, {28'd0, IDLE_V});
    check("midrst b", {28'd0, rd_b, busy_b, tx_b, done_b}, {28'd0, IDLE_V});
    reset_n = 1'b1;
    frame_q = '{8'h69};
    build_exp();
    run_check(run_len(), -1, 0, 8'h00, "postrst");
    tx_enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
